// File: rtl/alu_control_pipe.sv
// Registered ALU control decoder with valid/ready handshake.
// MULT/DIV commands keep the block busy for a fixed number of cycles after they leave.
module alu_control_pipe #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              jr,
    output logic              sign,
    output logic              multicycle,
    output logic              illegal,
    output logic              busy
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        BUSY
    } state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       jr;
        logic       sign;
        logic       multicycle;
        logic       illegal;
        logic       is_div;
    } dec_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    dec_t             dec;
    dec_t             held;
    logic             accept;

    // NOTE: every field gets a default before the case so no path leaves a latch or an X.
    always_comb begin
        dec      = '0;
        dec.code = OP_ADD;
        dec.sign = 1'b1;
        unique case (alu_op)
            2'b00: dec.code = OP_ADD;
            2'b01: dec.code = OP_SUB;
            2'b11: begin
                dec.code = OP_AND;
                dec.sign = 1'b0;
            end
            default: begin
                unique case (funct)
                    6'd32: dec.code = OP_ADD;
                    6'd34: dec.code = OP_SUB;
                    6'd36: begin dec.code = OP_AND; dec.sign = 1'b0; end
                    6'd37: begin dec.code = OP_OR;  dec.sign = 1'b0; end
                    6'd39: begin dec.code = OP_NOR; dec.sign = 1'b0; end
                    6'd42: dec.code = OP_SLT;
                    6'd0:  begin dec.code = OP_SLL; dec.sign = 1'b0; end
                    6'd2:  begin dec.code = OP_SRL; dec.sign = 1'b0; end
                    6'd8:  begin dec.code = OP_ADD; dec.jr = 1'b1; end
                    6'd24: begin dec.code = OP_MULT; dec.multicycle = 1'b1; end
                    6'd26: begin
                        dec.code       = OP_DIV;
                        dec.multicycle = 1'b1;
                        dec.is_div     = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
        endcase
    end

    // A held MULT/DIV never lets a new command in on the cycle it leaves.
    assign in_ready = reset_n &&
                      ((state == IDLE) ||
                       (state == HOLD && out_ready && !held.multicycle));
    assign accept   = in_valid && in_ready;

    // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            counter   <= '0;
            held      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (held.multicycle) begin
                            state     <= BUSY;
                            out_valid <= 1'b0;
                            busy      <= 1'b1;
                            counter   <= held.is_div ? CNT_W'(DIV_CYCLES - 1)
                                                     : CNT_W'(MUL_CYCLES - 1);
                        end else if (!in_valid) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (counter == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
            if (accept) begin
                held <= dec;
            end
        end
    end

    assign alucontrol = CTRL_W'(held.code);
    assign jr         = held.jr;
    assign sign       = held.sign;
    assign multicycle = held.multicycle;
    assign illegal    = held.illegal;

endmodule
